// File: rtl/ps2_key_fifo_if.sv
// Keyboard event FIFO bus: toggle-encoded key input, CPU pop/flush strobes, queue status.
interface ps2_key_fifo_if #(
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH) + 1
);
   logic [10:0]   ps2_key;
   logic          rd;
   logic          clear;
   logic          key_valid;
   logic [9:0]    key_data;
   logic [CW-1:0] key_count;
   logic          overflow;

   modport master (
      output ps2_key, rd, clear,
      input  key_valid, key_data, key_count, overflow
   );

   modport slave (
      input  ps2_key, rd, clear,
      output key_valid, key_data, key_count, overflow
   );
endinterface

// File: rtl/ps2_key_fifo.sv
// Turns each toggle of the ps2_key word into a queued {pressed, extended, code} event, popped by CPU reads.
// Optional typematic-repeat filter enabled by defining PS2_KEY_FIFO_REPEAT_FILTER_EN.
module ps2_key_fifo #(
   parameter int DEPTH = 16,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input logic            clk_24,
   input logic            reset_n,
   ps2_key_fifo_if.slave  bus
);
   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ZERO = AW'(0);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [9:0]    mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic [CW-1:0] count_nxt_s;
   logic          overflow_r;
   logic          primed_r;
   logic          prev_toggle_r;
   logic          key_valid_r;
   logic [9:0]    key_data_r;

   logic          push_req_s;
   logic          accept_s;
   logic          full_s;
   logic          pop_s;
   logic          do_push_s;
   logic          do_pop_s;
   logic          drop_s;

   // Toggle edge detection; nothing fires until the first post-reset edge has primed prev_toggle
   always_comb begin
      push_req_s = primed_r & (bus.ps2_key[10] != prev_toggle_r);
   end

`ifdef PS2_KEY_FIFO_REPEAT_FILTER_EN
   logic [9:0] last_make_r;
   logic       last_make_vld_r;
   logic       match_s;
   logic       repeat_s;

   // last_make always stores a make event, so its pressed bit is compared as a constant 1
   always_comb begin
      match_s  = last_make_vld_r & (last_make_r == {1'b1, bus.ps2_key[8:0]});
      repeat_s = bus.ps2_key[9] & match_s;
      accept_s = push_req_s & ~repeat_s;
   end

   // Typematic filter state: remembers the last accepted make until its matching break
   always_ff @(posedge clk_24 or negedge reset_n) begin
      if (!reset_n) begin
         last_make_r     <= 10'h000;
         last_make_vld_r <= 1'b0;
      end else if (bus.clear) begin
         last_make_vld_r <= 1'b0;
      end else if (accept_s && bus.ps2_key[9]) begin
         last_make_r     <= bus.ps2_key[9:0];
         last_make_vld_r <= 1'b1;
      end else if (push_req_s && !bus.ps2_key[9] && match_s) begin
         last_make_vld_r <= 1'b0;
      end
   end
`else
   // Without the filter every toggle is a candidate for the queue
   always_comb begin
      accept_s = push_req_s;
   end
`endif

   // Push/pop arbitration: a full FIFO still accepts a push when a pop frees a slot on the same edge
   always_comb begin
      full_s    = (count_r == CNT_FULL);
      pop_s     = bus.rd & (count_r != CNT_ZERO);
      do_push_s = accept_s & (~full_s | pop_s) & ~bus.clear;
      do_pop_s  = pop_s & ~bus.clear;
      drop_s    = accept_s & full_s & ~pop_s & ~bus.clear;
   end

   // Occupancy next-state
   always_comb begin
      case ({do_push_s, do_pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointers, occupancy, status flags; clear outranks push and pop
   always_ff @(posedge clk_24 or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r    <= PTR_ZERO;
         rd_ptr_r    <= PTR_ZERO;
         count_r     <= CNT_ZERO;
         overflow_r  <= 1'b0;
         key_valid_r <= 1'b0;
      end else if (bus.clear) begin
         wr_ptr_r    <= PTR_ZERO;
         rd_ptr_r    <= PTR_ZERO;
         count_r     <= CNT_ZERO;
         overflow_r  <= 1'b0;
         key_valid_r <= 1'b0;
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         if (drop_s)    overflow_r <= 1'b1;
         count_r     <= count_nxt_s;
         key_valid_r <= (count_nxt_s != CNT_ZERO);
      end
   end

   // prev_toggle follows the input on every edge, including clear edges, so no phantom event follows
   always_ff @(posedge clk_24 or negedge reset_n) begin
      if (!reset_n) begin
         primed_r      <= 1'b0;
         prev_toggle_r <= 1'b0;
      end else begin
         primed_r      <= 1'b1;
         prev_toggle_r <= bus.ps2_key[10];
      end
   end

   // Event storage
   always_ff @(posedge clk_24) begin
      if (do_push_s) mem_r[wr_ptr_r] <= bus.ps2_key[9:0];
   end

   // Registered head read; holds its last value while empty
   always_ff @(posedge clk_24 or negedge reset_n) begin
      if (!reset_n) begin
         key_data_r <= 10'h000;
      end else if (count_r != CNT_ZERO) begin
         key_data_r <= mem_r[rd_ptr_r];
      end
   end

   assign bus.key_valid = key_valid_r;
   assign bus.key_data  = key_data_r;
   assign bus.key_count = count_r;
   assign bus.overflow  = overflow_r;
endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed bench for ps2_key_fifo (DEPTH=16): reset, priming, ordering, overflow, full push+pop, clear, repeat filter.
module tb_ps2_key_fifo;
   logic clk = 1'b0;
   logic reset_n;
   logic tog;
   int   vectors = 0;
   int   miscompares = 0;

   ps2_key_fifo_if #(.DEPTH(16)) bus ();

   ps2_key_fifo #(.DEPTH(16)) dut (
      .clk_24  (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [9:0] ev);
      tog = ~tog;
      bus.ps2_key = {tog, ev};
      tick();
   endtask

   task automatic pop();
      bus.rd = 1'b1;
      tick();
      bus.rd = 1'b0;
      tick();
   endtask

   logic [9:0] exp6 [5];
   int         n6;

   initial begin
      reset_n     = 1'b0;
      bus.ps2_key = 11'h400;
      bus.rd      = 1'b0;
      bus.clear   = 1'b0;
      tog         = 1'b1;
      repeat (3) tick();
      chk("reset_valid", 32'(bus.key_valid), 32'h0);
      chk("reset_data",  32'(bus.key_data),  32'h0);
      chk("reset_count", 32'(bus.key_count), 32'h0);
      chk("reset_ovf",   32'(bus.overflow),  32'h0);

      // Test 1: toggle already high at release must not produce an event
      reset_n = 1'b1;
      tick();
      tick();
      chk("prime_count", 32'(bus.key_count), 32'h0);
      chk("prime_valid", 32'(bus.key_valid), 32'h0);
      tog = 1'b0;
      bus.ps2_key = 11'h21C;
      tick();
      tick();
      chk("t1_valid", 32'(bus.key_valid), 32'h1);
      chk("t1_data",  32'(bus.key_data),  32'h21C);
      chk("t1_count", 32'(bus.key_count), 32'h1);
      pop();
      chk("t1_empty", 32'(bus.key_valid), 32'h0);
      chk("t1_hold",  32'(bus.key_data),  32'h21C);
      bus.rd = 1'b1;
      tick();
      bus.rd = 1'b0;
      chk("rd_empty_count", 32'(bus.key_count), 32'h0);

      // Test 2: ordering
      for (int i = 1; i <= 5; i++) send(10'h200 | 10'(i));
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("t2_data",  32'(bus.key_data),  32'h201 + 32'(i));
         chk("t2_count", 32'(bus.key_count), 32'(5 - i));
         pop();
      end
      chk("t2_valid", 32'(bus.key_valid), 32'h0);
      chk("t2_count0", 32'(bus.key_count), 32'h0);

      // Test 3: overflow on 17th event
      for (int i = 0; i < 17; i++) send(10'h210 + 10'(i));
      tick();
      chk("t3_count", 32'(bus.key_count), 32'd16);
      chk("t3_ovf",   32'(bus.overflow),  32'h1);
      for (int i = 0; i < 16; i++) begin
         chk("t3_data", 32'(bus.key_data), 32'h210 + 32'(i));
         pop();
      end
      chk("t3_valid",   32'(bus.key_valid), 32'h0);
      chk("t3_ovf_pop", 32'(bus.overflow),  32'h1);
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      chk("t3_ovf_clr", 32'(bus.overflow), 32'h0);

      // Test 4: full FIFO, push and pop on the same edge
      for (int i = 0; i < 16; i++) send(10'h230 + 10'(i));
      chk("t4_full", 32'(bus.key_count), 32'd16);
      tog = ~tog;
      bus.ps2_key = {tog, 10'h240};
      bus.rd = 1'b1;
      tick();
      bus.rd = 1'b0;
      chk("t4_count", 32'(bus.key_count), 32'd16);
      chk("t4_ovf",   32'(bus.overflow),  32'h0);
      tick();
      for (int i = 0; i < 16; i++) begin
         chk("t4_data", 32'(bus.key_data), (i < 15) ? 32'h231 + 32'(i) : 32'h240);
         pop();
      end
      chk("t4_empty", 32'(bus.key_count), 32'h0);

      // Test 5: clear with a simultaneous toggle
      for (int i = 0; i < 3; i++) send(10'h260 + 10'(i));
      tog = ~tog;
      bus.ps2_key = {tog, 10'h250};
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      chk("t5_count", 32'(bus.key_count), 32'h0);
      chk("t5_valid", 32'(bus.key_valid), 32'h0);
      chk("t5_ovf",   32'(bus.overflow),  32'h0);
      tick();
      chk("t5_nophantom", 32'(bus.key_count), 32'h0);
      send(10'h251);
      tick();
      chk("t5_next_count", 32'(bus.key_count), 32'h1);
      chk("t5_next_data",  32'(bus.key_data),  32'h251);
      pop();

      // Test 6: typematic repeat stimulus
`ifdef PS2_KEY_FIFO_REPEAT_FILTER_EN
      exp6[0] = 10'h21C; exp6[1] = 10'h01C; exp6[2] = 10'h21C; exp6[3] = 10'h000; exp6[4] = 10'h000;
      n6 = 3;
`else
      exp6[0] = 10'h21C; exp6[1] = 10'h21C; exp6[2] = 10'h21C; exp6[3] = 10'h01C; exp6[4] = 10'h21C;
      n6 = 5;
`endif
      send(10'h21C);
      send(10'h21C);
      send(10'h21C);
      send(10'h01C);
      send(10'h21C);
      tick();
      chk("t6_count", 32'(bus.key_count), 32'(n6));
      for (int i = 0; i < n6; i++) begin
         chk("t6_data", 32'(bus.key_data), 32'(exp6[i]));
         pop();
      end
      chk("t6_empty", 32'(bus.key_valid), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
